md_sequencer: RTL and testbench

Iterative unsigned multiply/divide sequencer for the MIPS pipeline. It uses the shared 32-bit ALU (3-bit op: 000 add, 001 sub) for MULTU and DIVU, one shift-add or shift-subtract step per cycle. It owns the architectural HI/LO registers and raises busy so the hazard unit stalls mfhi/mflo and further mult/div issue. It drives the ALU operand and op lines only while an operation is in flight; the top level muxes these with the EX-stage operands using busy.

---
 rtl/md_sequencer.sv | 169 ++++++++++++++++
 tb/tb_md_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : md_sequencer
// Brief    : Iterative unsigned MULTU/DIVU sequencer built on the shared
//            32-bit ALU (one shift-add or restoring shift-subtract step per
//            cycle). Owns the architectural HI/LO registers and raises busy
//            so the hazard unit can stall mfhi/mflo and further mult/div.
// Revision : 1.0 - initial release
// ============================================================================
module md_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   input  logic [31:0] alu_result,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_op,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_zero
);

   localparam logic [1:0] c_OP_MULTU = 2'b00;
   localparam logic [1:0] c_OP_DIVU  = 2'b01;
   localparam logic [1:0] c_OP_MTHI  = 2'b10;
   localparam logic [1:0] c_OP_MTLO  = 2'b11;
   localparam logic [2:0] c_ALU_ADD  = 3'b000;
   localparam logic [2:0] c_ALU_SUB  = 3'b001;
   localparam logic [5:0] c_LAST_CNT = 6'd31;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_wh;
   logic [31:0] r_wl;
   logic [31:0] r_d;
   logic [5:0]  r_cnt;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_div_zero;

   // Restoring-divide partial remainder: shift the next dividend bit in.
   // w_top is the bit shifted out; when set, the 33-bit value is >= divisor.
   logic [31:0] w_s;
   logic        w_top;
   logic        w_ge;
   logic        w_carry;
   logic [31:0] w_mul_wh;
   logic [31:0] w_mul_wl;
   logic [31:0] w_div_wh;
   logic [31:0] w_div_wl;

   assign w_s     = {r_wh[30:0], r_wl[31]};
   assign w_top   = r_wh[31];
   assign w_ge    = w_top | (w_s >= r_d);
   // Unsigned overflow of wh + d shows up as a wrapped sum smaller than wh.
   assign w_carry = (alu_result < r_wh);

   // Next working pair for one multiply step and one divide step.
   always_comb begin
      if (r_wl[0]) begin
         w_mul_wh = {w_carry, alu_result[31:1]};
         w_mul_wl = {alu_result[0], r_wl[31:1]};
      end else begin
         w_mul_wh = {1'b0, r_wh[31:1]};
         w_mul_wl = {r_wh[0], r_wl[31:1]};
      end
      w_div_wh = w_ge ? alu_result : w_s;
      w_div_wl = {r_wl[30:0], w_ge};
   end

   // ALU request lines: only driven while an operation is in flight.
   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_op = c_ALU_ADD;
      case (r_state)
         S_MUL: begin
            alu_a  = r_wh;
            alu_b  = r_d;
            alu_op = c_ALU_ADD;
         end
         S_DIV: begin
            alu_a  = w_s;
            alu_b  = r_d;
            alu_op = c_ALU_SUB;
         end
         default: ;
      endcase
   end

   assign busy     = (r_state != S_IDLE);
   assign hi       = r_hi;
   assign lo       = r_lo;
   assign div_zero = r_div_zero;

   // Sequencer: issue in IDLE, one step per cycle, commit HI/LO on step 31.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_wh       <= '0;
         r_wl       <= '0;
         r_d        <= '0;
         r_cnt      <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_div_zero <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  case (op)
                     c_OP_MTHI: r_hi <= rs;
                     c_OP_MTLO: r_lo <= rs;
                     c_OP_MULTU: begin
                        r_wh       <= '0;
                        r_wl       <= rt;
                        r_d        <= rs;
                        r_cnt      <= '0;
                        r_div_zero <= 1'b0;
                        r_state    <= S_MUL;
                     end
                     c_OP_DIVU: begin
                        r_wh       <= '0;
                        r_wl       <= rs;
                        r_d        <= rt;
                        r_cnt      <= '0;
                        r_div_zero <= (rt == 32'd0);
                        r_state    <= S_DIV;
                     end
                     default: ;
                  endcase
               end
            end
            S_MUL: begin
               r_wh  <= w_mul_wh;
               r_wl  <= w_mul_wl;
               r_cnt <= r_cnt + 6'd1;
               if (r_cnt == c_LAST_CNT) begin
                  r_hi    <= w_mul_wh;
                  r_lo    <= w_mul_wl;
                  r_state <= S_IDLE;
               end
            end
            S_DIV: begin
               r_wh  <= w_div_wh;
               r_wl  <= w_div_wl;
               r_cnt <= r_cnt + 6'd1;
               if (r_cnt == c_LAST_CNT) begin
                  r_hi    <= w_div_wh;
                  r_lo    <= w_div_wl;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_md_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_sequencer
// Brief    : Self-checking bench for md_sequencer. Provides the shared ALU,
//            drives directed and random MULTU/DIVU/MTHI/MTLO traffic and
//            compares against 64-bit arithmetic results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs;
   logic [31:0] rt;
   logic [31:0] alu_result;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [2:0]  alu_op;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_zero;

   int checks = 0;
   int errors = 0;

   md_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .op         (op),
      .rs         (rs),
      .rt         (rt),
      .alu_result (alu_result),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .busy       (busy),
      .hi         (hi),
      .lo         (lo),
      .div_zero   (div_zero)
   );

   // Shared ALU: add or subtract, single-cycle combinational.
   assign alu_result = (alu_op == 3'b001) ? (alu_a - alu_b) : (alu_a + alu_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one op at a negedge and wait (bounded) until busy drops.
   // Returns the number of busy cycles and whether hi/lo held meanwhile.
   task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output bit held);
      logic [31:0] h0, l0;
      h0 = hi;
      l0 = lo;
      op = o; rs = a; rt = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rs = $urandom; rt = $urandom;
      cyc = 0;
      held = 1'b1;
      while (busy && cyc < 100) begin
         cyc++;
         if (hi !== h0 || lo !== l0) held = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; op = 2'b00; rs = '0; rt = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({hi, lo, busy, div_zero} !== {64'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state hi=%h lo=%h busy=%b dz=%b required 0", hi, lo, busy, div_zero);
      end
      checks++;
      if ({alu_a, alu_b, alu_op} !== 67'd0) begin
         errors++;
         $display("FAIL reset_alu a=%h b=%h op=%b required 0", alu_a, alu_b, alu_op);
      end
   endtask

   task automatic test_mul;
      int cyc; bit held;
      logic [63:0] p;
      // Check first-step ALU request of a MULTU.
      op = 2'b00; rs = 32'hFFFFFFFF; rt = 32'hFFFFFFFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (alu_a !== 32'd0 || alu_b !== 32'hFFFFFFFF || alu_op !== 3'b000 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mul_alu_req a=%h b=%h op=%b busy=%b required a=0 b=ffffffff op=000 busy=1",
                  alu_a, alu_b, alu_op, busy);
      end
      cyc = 1;
      while (busy && cyc < 100) begin @(negedge clk); if (busy) cyc++; end
      checks++;
      if (cyc !== 32 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
         errors++;
         $display("FAIL mul_ffff cycles=%0d hi=%h lo=%h required 32 fffffffe 00000001", cyc, hi, lo);
      end
      p = 64'h12345678 * 64'h10;
      do_op(2'b00, 32'h12345678, 32'h10, cyc, held);
      checks++;
      if (cyc !== 32 || hi !== p[63:32] || lo !== p[31:0] || !held) begin
         errors++;
         $display("FAIL mul_12345678 cycles=%0d hi=%h lo=%h held=%b required 32 %h %h 1",
                  cyc, hi, lo, held, p[63:32], p[31:0]);
      end
   endtask

   task automatic test_div;
      int cyc; bit held;
      op = 2'b01; rs = 32'd100; rt = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      // First restoring step compares the dividend MSB against the divisor.
      checks++;
      if (alu_a !== 32'd0 || alu_b !== 32'd7 || alu_op !== 3'b001) begin
         errors++;
         $display("FAIL div_alu_req a=%h b=%h op=%b required 0 7 001", alu_a, alu_b, alu_op);
      end
      cyc = 1;
      while (busy && cyc < 100) begin @(negedge clk); if (busy) cyc++; end
      checks++;
      if (cyc !== 32 || hi !== 32'd2 || lo !== 32'd14 || div_zero !== 1'b0) begin
         errors++;
         $display("FAIL div_100_7 cycles=%0d hi=%h lo=%h dz=%b required 32 2 e 0", cyc, hi, lo, div_zero);
      end
      do_op(2'b01, 32'hFFFFFFFF, 32'h80000000, cyc, held);
      checks++;
      if (cyc !== 32 || hi !== 32'h7FFFFFFF || lo !== 32'h1 || !held) begin
         errors++;
         $display("FAIL div_msb cycles=%0d hi=%h lo=%h held=%b required 32 7fffffff 1 1", cyc, hi, lo, held);
      end
   endtask

   task automatic test_div_zero;
      int cyc; bit held;
      do_op(2'b01, 32'h12345678, 32'd0, cyc, held);
      checks++;
      if (cyc !== 32 || hi !== 32'h12345678 || lo !== 32'hFFFFFFFF || div_zero !== 1'b1) begin
         errors++;
         $display("FAIL div_zero cycles=%0d hi=%h lo=%h dz=%b required 32 12345678 ffffffff 1",
                  cyc, hi, lo, div_zero);
      end
      op = 2'b00; rs = 32'd3; rt = 32'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (div_zero !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL dz_clear dz=%b busy=%b required 0 1", div_zero, busy);
      end
      cyc = 1;
      while (busy && cyc < 100) begin @(negedge clk); if (busy) cyc++; end
      checks++;
      if (cyc !== 32 || hi !== 32'd0 || lo !== 32'd12) begin
         errors++;
         $display("FAIL mul_3_4 cycles=%0d hi=%h lo=%h required 32 0 c", cyc, hi, lo);
      end
   endtask

   task automatic test_mthi_mtlo;
      int cyc; bit held;
      logic [31:0] l0;
      l0 = lo;
      op = 2'b10; rs = 32'hAAAA5555; start = 1'b1;
      @(negedge clk);
      op = 2'b11; rs = 32'h0F0F0F0F;
      checks++;
      if (hi !== 32'hAAAA5555 || lo !== l0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mthi hi=%h lo=%h busy=%b required aaaa5555 %h 0", hi, lo, busy, l0);
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (hi !== 32'hAAAA5555 || lo !== 32'h0F0F0F0F || busy !== 1'b0) begin
         errors++;
         $display("FAIL mtlo hi=%h lo=%h busy=%b required aaaa5555 0f0f0f0f 0", hi, lo, busy);
      end
      // MTHI issued while a MULTU is busy must be ignored.
      op = 2'b00; rs = 32'd1000; rt = 32'd1000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      op = 2'b10; rs = 32'hDEADBEEF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (hi !== 32'hAAAA5555 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mthi_busy hi=%h busy=%b required aaaa5555 1", hi, busy);
      end
      cyc = 0;
      while (busy && cyc < 100) begin @(negedge clk); cyc++; end
      checks++;
      if (hi !== 32'd0 || lo !== 32'd1000000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mul_after_mthi hi=%h lo=%h busy=%b required 0 f4240 0", hi, lo, busy);
      end
   endtask

   task automatic test_reset_midop;
      int cyc; bit held;
      op = 2'b00; rs = 32'd3; rt = 32'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_cycle10 busy=%b required 1", busy);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || div_zero !== 1'b0 || alu_a !== 32'd0) begin
         errors++;
         $display("FAIL reset_midop busy=%b hi=%h lo=%h dz=%b a=%h required 0 0 0 0 0",
                  busy, hi, lo, div_zero, alu_a);
      end
      do_op(2'b01, 32'd9, 32'd2, cyc, held);
      checks++;
      if (cyc !== 32 || hi !== 32'd1 || lo !== 32'd4) begin
         errors++;
         $display("FAIL div_9_2 cycles=%0d hi=%h lo=%h required 32 1 4", cyc, hi, lo);
      end
   endtask

   // Back-to-back random ops: each new start issues on the first idle cycle.
   task automatic test_random;
      int cyc; bit held;
      logic [1:0]  o;
      logic [31:0] a, b;
      logic [63:0] p;
      logic [31:0] exp_hi, exp_lo;
      logic        exp_dz;
      int          exp_cyc;
      exp_hi = hi; exp_lo = lo; exp_dz = div_zero;
      for (int i = 0; i < 30; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = 32'd0;
            1: b = $urandom_range(1, 255);
            default: b = $urandom;
         endcase
         exp_cyc = 0;
         case (o)
            2'b00: begin
               p = {32'd0, a} * {32'd0, b};
               exp_hi = p[63:32]; exp_lo = p[31:0]; exp_dz = 1'b0; exp_cyc = 32;
            end
            2'b01: begin
               exp_cyc = 32;
               if (b == 0) begin
                  exp_hi = a; exp_lo = 32'hFFFFFFFF; exp_dz = 1'b1;
               end else begin
                  exp_hi = a % b; exp_lo = a / b; exp_dz = 1'b0;
               end
            end
            2'b10: exp_hi = a;
            default: exp_lo = a;
         endcase
         do_op(o, a, b, cyc, held);
         checks++;
         if (cyc !== exp_cyc || hi !== exp_hi || lo !== exp_lo || div_zero !== exp_dz || !held) begin
            errors++;
            $display("FAIL random_%0d op=%b rs=%h rt=%h got cyc=%0d hi=%h lo=%h dz=%b held=%b required cyc=%0d hi=%h lo=%h dz=%b",
                     i, o, a, b, cyc, hi, lo, div_zero, held, exp_cyc, exp_hi, exp_lo, exp_dz);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_div_zero();
      test_mthi_mtlo();
      test_reset_midop();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
